mem_wb_stage: RTL and testbench
===============================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have port: clk  in  1  sole clock; all state updates on posedge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high; sampled on posedge clk.
REQ-003 SHALL have port: m_valid  in  1  MEM stage holds a real instruction (0 = bubble).
REQ-004 SHALL have ports: m_pc  in  32  instruction PC; m_rd  in  5  destination register; m_we  in  1  instruction writes GRF.
REQ-005 SHALL have port: m_wsel  in  2  write-data source: 0 ALU, 1 memory, 2 PC+8, 3 reserved.
REQ-006 SHALL have ports: m_alu  in  32  ALU result / data address; m_dm_rdata  in  32  aligned word read from DM.
REQ-007 SHALL have port: m_ld_type  in  3  load type: 0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU, others = LW.
REQ-008 SHALL have ports: w_we  out  1; w_a3  out  5; w_wd  out  32; w_pc  out  32. These drive GRF WE/A3/WD/PC directly.
REQ-009 SHALL have port: retire_cnt  out  32  count of instructions completed in WB.

Function
REQ-010 SHALL capture all m_* inputs into the MEM/WB register on every posedge clk; no stall or enable input.
REQ-011 w_* outputs SHALL be combinational from the register only: one-cycle latency MEM->WB; GRF commits on the following edge.
REQ-012 w_we SHALL = v_q & we_q & (rd_q != 0); w_a3 SHALL = rd_q when v_q, else 0.
REQ-013 w_pc SHALL = pc_q.
REQ-014 w_wd for wsel 0 SHALL = alu_q; for wsel 2 SHALL = pc_q + 8, modulo 2^32 (0xFFFFFFFC -> 0x00000004).
REQ-015 wsel 3 SHALL force w_wd = 0 and w_we = 0.
REQ-016 Memory data SHALL use byte offset alu_q[1:0]: LB/LBU select byte at offset, sign- or zero-extended to 32 bits.
REQ-017 LH/LHU SHALL select halfword by alu_q[1] (alu_q[0] ignored), sign- or zero-extended; LW SHALL pass the word unchanged.
REQ-018 Bubble (v_q=0) SHALL give w_we=0 regardless of other fields; w_wd remains a don't-care that is computed deterministically.
REQ-019 retire_cnt SHALL increment by 1 on each posedge where v_q=1 and reset=0; it wraps from 0xFFFFFFFF to 0.
REQ-020 Back-to-back valid instructions SHALL each appear on w_* for exactly one cycle; there is no inter-stage bypass here, and forwarding taps w_a3/w_wd/w_we.

Reset
REQ-021 reset=1 at posedge SHALL clear v_q, we_q, rd_q, wsel_q, ld_q, alu_q, rdata_q, pc_q and retire_cnt to 0, with priority over capture.
REQ-022 After reset, outputs SHALL be w_we=0, w_a3=0, w_wd=0, w_pc=0 and retire_cnt=0 until the first valid capture.
REQ-023 Reset asserted mid-stream SHALL discard the instruction in WB, issue no GRF write, and not increment retire_cnt on that edge.

Structure
REQ-024 Shared package SHALL hold WSEL_ALU/MEM/PC8 codes, LD_LW/LB/LBU/LH/LHU codes and the PC+8 constant 32'd8.
REQ-025 Load extension SHALL be one combinational sub-module, load_ext (inputs: word, offset[1:0], ld_type; output: 32-bit data).
REQ-026 The block SHALL contain no memories; state is the MEM/WB register plus retire_cnt.

Verification
REQ-027 Inputs m_valid=1, m_we=1, m_rd=8, m_wsel=0, m_alu=0x12345678, m_pc=0x3000 -> next cycle: w_we=1, w_a3=8, w_wd=0x12345678, w_pc=0x3000, and retire_cnt +1 on the following edge.
REQ-028 m_dm_rdata=0x80FF7F01 with m_alu[1:0]=2: LB -> 0xFFFFFFFF; LBU -> 0x000000FF; alu[1:0]=3 LB -> 0xFFFFFF80; LH with alu[1]=0 -> 0x00007F01; LHU with alu[1]=1 -> 0x000080FF.
REQ-029 jal case: m_wsel=2, m_rd=31, m_pc=0x3010 -> w_wd=0x3018; m_pc=0xFFFFFFFC -> w_wd=0x00000004.
REQ-030 m_rd=0 with m_we=1, then m_valid=0, then m_wsel=3 -> w_we=0 in all three cycles; retire_cnt increments for the rd=0 and wsel=3 instructions only.
REQ-031 Reset asserted while a valid write sits in WB -> w_we=0 and retire_cnt=0 the next cycle; force retire_cnt to 0xFFFFFFFF, then one valid instruction -> 0.

Source files
------------

// File: rtl/mem_wb_pkg.sv
// MEM/WB shared definitions: write-back source codes,
// load type codes, PC+8 link offset and the pipeline register bundle.
package mem_wb_pkg;

  localparam logic [1:0] WSEL_ALU = 2'd0;
  localparam logic [1:0] WSEL_MEM = 2'd1;
  localparam logic [1:0] WSEL_PC8 = 2'd2;
  localparam logic [1:0] WSEL_RSV = 2'd3;

  localparam logic [2:0] LD_LW  = 3'd0;
  localparam logic [2:0] LD_LB  = 3'd1;
  localparam logic [2:0] LD_LBU = 3'd2;
  localparam logic [2:0] LD_LH  = 3'd3;
  localparam logic [2:0] LD_LHU = 3'd4;

  localparam logic [31:0] PC8_OFF = 32'd8;

  typedef struct packed {
    logic        v;
    logic        we;
    logic [4:0]  rd;
    logic [1:0]  wsel;
    logic [2:0]  ld;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc;
  } mem_wb_t;

endpackage

// File: rtl/mem_wb_stage_load_ext.sv
// Load data extraction: picks byte/halfword from an aligned word.
// Ports: word, offset[1:0], ld_type in; data (32-bit extended) out.
import mem_wb_pkg::*;

module load_ext (
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  ld_type,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = '0;
    unique case (offset)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
  end

  // Halfword uses offset[1] only; misaligned bit 0 is ignored.
  assign half_sel = offset[1] ? word[31:16] : word[15:0];

  always_comb begin
    data = word;
    unique case (ld_type)
      LD_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  data = {24'd0, byte_sel};
      LD_LH:   data = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  data = {16'd0, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and write-back mux driving the GRF.
// Ports: clk, reset, m_* from MEM; w_we/w_a3/w_wd/w_pc to GRF; retire_cnt.
import mem_wb_pkg::*;

module mem_wb_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_valid,
  input  logic [31:0] m_pc,
  input  logic [4:0]  m_rd,
  input  logic        m_we,
  input  logic [1:0]  m_wsel,
  input  logic [31:0] m_alu,
  input  logic [31:0] m_dm_rdata,
  input  logic [2:0]  m_ld_type,
  output logic        w_we,
  output logic [4:0]  w_a3,
  output logic [31:0] w_wd,
  output logic [31:0] w_pc,
  output logic [31:0] retire_cnt
);

  mem_wb_t     wb_d, wb_q;
  logic [31:0] retire_cnt_d, retire_cnt_q;
  logic [31:0] ld_data;

  always_comb begin
    wb_d.v     = m_valid;
    wb_d.we    = m_we;
    wb_d.rd    = m_rd;
    wb_d.wsel  = m_wsel;
    wb_d.ld    = m_ld_type;
    wb_d.alu   = m_alu;
    wb_d.rdata = m_dm_rdata;
    wb_d.pc    = m_pc;
  end

  assign retire_cnt_d = retire_cnt_q + {31'd0, wb_q.v};

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_q         <= '0;
      retire_cnt_q <= '0;
    end else begin
      wb_q         <= wb_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  load_ext u_load_ext (
    .word    (wb_q.rdata),
    .offset  (wb_q.alu[1:0]),
    .ld_type (wb_q.ld),
    .data    (ld_data)
  );

  always_comb begin
    w_wd = '0;
    unique case (wb_q.wsel)
      WSEL_ALU: w_wd = wb_q.alu;
      WSEL_MEM: w_wd = ld_data;
      WSEL_PC8: w_wd = wb_q.pc + PC8_OFF;
      default:  w_wd = '0;
    endcase
  end

  assign w_we = wb_q.v & wb_q.we & (wb_q.rd != 5'd0)
              & (wb_q.wsel != WSEL_RSV);
  assign w_a3 = wb_q.v ? wb_q.rd : 5'd0;
  assign w_pc = wb_q.pc;
  assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: reference model plus
// directed vectors with hand-computed literal expectations.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_valid;
  logic [31:0] m_pc;
  logic [4:0]  m_rd;
  logic        m_we;
  logic [1:0]  m_wsel;
  logic [31:0] m_alu;
  logic [31:0] m_dm_rdata;
  logic [2:0]  m_ld_type;
  logic        w_we;
  logic [4:0]  w_a3;
  logic [31:0] w_wd;
  logic [31:0] w_pc;
  logic [31:0] retire_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk        (clk),
    .reset      (reset),
    .m_valid    (m_valid),
    .m_pc       (m_pc),
    .m_rd       (m_rd),
    .m_we       (m_we),
    .m_wsel     (m_wsel),
    .m_alu      (m_alu),
    .m_dm_rdata (m_dm_rdata),
    .m_ld_type  (m_ld_type),
    .w_we       (w_we),
    .w_a3       (w_a3),
    .w_wd       (w_wd),
    .w_pc       (w_pc),
    .retire_cnt (retire_cnt)
  );

  typedef struct {
    bit        v;
    bit        we;
    bit [4:0]  rd;
    bit [1:0]  wsel;
    bit [2:0]  ld;
    bit [31:0] alu;
    bit [31:0] rdata;
    bit [31:0] pc;
  } instr_t;

  instr_t    md_wb;
  bit [31:0] md_cnt;
  bit        armed = 0;
  bit        preload = 0;

  function automatic bit [31:0] sext(bit [31:0] x, int bits);
    bit [31:0] m;
    m = (32'd1 << bits) - 1;
    x = x & m;
    if (x[bits-1]) return x | ~m;
    return x;
  endfunction

  function automatic bit [31:0] exp_wd(instr_t r);
    int off;
    bit [31:0] b, h;
    off = int'(r.alu[1:0]);
    b = (r.rdata >> (8 * off)) & 32'hFF;
    h = (r.rdata >> (16 * (off / 2))) & 32'hFFFF;
    if (r.wsel == 2'd0) return r.alu;
    if (r.wsel == 2'd2) return r.pc + 32'd8;
    if (r.wsel == 2'd3) return 32'd0;
    case (r.ld)
      3'd1: return sext(b, 8);
      3'd2: return b;
      3'd3: return sext(h, 16);
      3'd4: return h;
      default: return r.rdata;
    endcase
  endfunction

  // Reference model: last captured instruction and retired count.
  always @(posedge clk) begin
    if (reset) begin
      md_wb  <= '{default: 0};
      md_cnt <= 32'd0;
    end else begin
      md_wb.v     <= m_valid;
      md_wb.we    <= m_we;
      md_wb.rd    <= m_rd;
      md_wb.wsel  <= m_wsel;
      md_wb.ld    <= m_ld_type;
      md_wb.alu   <= m_alu;
      md_wb.rdata <= m_dm_rdata;
      md_wb.pc    <= m_pc;
      md_cnt <= (preload ? 32'hFFFF_FFFF : md_cnt) + {31'd0, md_wb.v};
    end
  end

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      bit ewe;
      ewe = md_wb.v && md_wb.we && md_wb.rd != 0 && md_wb.wsel != 3;
      cmp("model_we", {31'd0, w_we}, {31'd0, ewe});
      cmp("model_a3", {27'd0, w_a3}, md_wb.v ? {27'd0, md_wb.rd} : 32'd0);
      cmp("model_wd", w_wd, exp_wd(md_wb));
      cmp("model_pc", w_pc, md_wb.pc);
      cmp("model_cnt", retire_cnt, md_cnt);
    end
  end

  task automatic put(bit v, bit we, bit [4:0] rd, bit [1:0] ws,
                     bit [2:0] ld, bit [31:0] alu, bit [31:0] rdat,
                     bit [31:0] pc);
    @(negedge clk);
    reset = 0; m_valid = v; m_we = we; m_rd = rd; m_wsel = ws;
    m_ld_type = ld; m_alu = alu; m_dm_rdata = rdat; m_pc = pc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; m_valid = 0;
    @(posedge clk);
    #1;
  endtask

  localparam bit [31:0] RD = 32'h80FF7F01;

  initial begin
    reset = 1; m_valid = 0; m_we = 0; m_rd = 0; m_wsel = 0;
    m_ld_type = 0; m_alu = 0; m_dm_rdata = 0; m_pc = 0;
    @(posedge clk);
    #1;
    armed = 1;
    cmp("rst_we", {31'd0, w_we}, 32'd0);
    cmp("rst_a3", {27'd0, w_a3}, 32'd0);
    cmp("rst_wd", w_wd, 32'd0);
    cmp("rst_pc", w_pc, 32'd0);
    cmp("rst_cnt", retire_cnt, 32'd0);

    put(1, 1, 8, 0, 0, 32'h12345678, 0, 32'h3000);
    cmp("alu_we", {31'd0, w_we}, 32'd1);
    cmp("alu_a3", {27'd0, w_a3}, 32'd8);
    cmp("alu_wd", w_wd, 32'h12345678);
    cmp("alu_pc", w_pc, 32'h3000);
    cmp("alu_cnt0", retire_cnt, 32'd0);
    put(1, 1, 2, 1, 1, 32'h2, RD, 32'h3004);
    cmp("alu_cnt1", retire_cnt, 32'd1);
    cmp("lb_off2", w_wd, 32'hFFFFFFFF);
    put(1, 1, 2, 1, 2, 32'h2, RD, 32'h3008);
    cmp("lbu_off2", w_wd, 32'h000000FF);
    put(1, 1, 2, 1, 1, 32'h3, RD, 32'h300C);
    cmp("lb_off3", w_wd, 32'hFFFFFF80);
    put(1, 1, 2, 1, 1, 32'h0, RD, 32'h300C);
    cmp("lb_off0", w_wd, 32'h00000001);
    put(1, 1, 2, 1, 3, 32'h1, RD, 32'h3010);
    cmp("lh_lo", w_wd, 32'h00007F01);
    put(1, 1, 2, 1, 3, 32'h3, RD, 32'h3010);
    cmp("lh_hi", w_wd, 32'hFFFF80FF);
    put(1, 1, 2, 1, 4, 32'h2, RD, 32'h3014);
    cmp("lhu_hi", w_wd, 32'h000080FF);
    put(1, 1, 2, 1, 0, 32'h1, RD, 32'h3018);
    cmp("lw", w_wd, RD);
    put(1, 1, 2, 1, 7, 32'h2, RD, 32'h301C);
    cmp("ld7_as_lw", w_wd, RD);
    put(1, 1, 31, 2, 0, 32'hDEAD, 0, 32'h3010);
    cmp("jal_wd", w_wd, 32'h3018);
    cmp("jal_a3", {27'd0, w_a3}, 32'd31);
    put(1, 1, 31, 2, 0, 32'hDEAD, 0, 32'hFFFFFFFC);
    cmp("jal_wrap", w_wd, 32'h00000004);

    do_reset();
    put(1, 1, 0, 0, 0, 32'h55, 0, 32'h4000);
    cmp("rd0_we", {31'd0, w_we}, 32'd0);
    put(0, 1, 9, 0, 0, 32'h66, 0, 32'h4004);
    cmp("bub_we", {31'd0, w_we}, 32'd0);
    cmp("bub_a3", {27'd0, w_a3}, 32'd0);
    put(1, 1, 9, 3, 0, 32'h77, 0, 32'h4008);
    cmp("ws3_we", {31'd0, w_we}, 32'd0);
    cmp("ws3_wd", w_wd, 32'd0);
    put(0, 0, 0, 0, 0, 0, 0, 0);
    cmp("cnt_two", retire_cnt, 32'd2);

    put(1, 1, 5, 0, 0, 32'hA, 0, 32'h5000);
    put(1, 1, 6, 0, 0, 32'hB, 0, 32'h5004);
    cmp("b2b_a3", {27'd0, w_a3}, 32'd6);
    cmp("b2b_wd", w_wd, 32'hB);
    @(negedge clk);
    reset = 1;
    @(posedge clk);
    #1;
    cmp("mid_rst_we", {31'd0, w_we}, 32'd0);
    cmp("mid_rst_cnt", retire_cnt, 32'd0);

    put(1, 1, 3, 0, 0, 32'h99, 0, 32'h6000);
    @(negedge clk);
    m_valid = 0;
    #2;
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    preload = 1;
    #1;
    release dut.retire_cnt_q;
    @(posedge clk);
    #1;
    preload = 0;
    cmp("cnt_wrap", retire_cnt, 32'd0);
    put(0, 0, 0, 0, 0, 0, 0, 0);
    put(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    armed = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
